credential_entry: RTL
=====================

Name: credential_entry

Overview:
- Front-end entry stage directly upstream of the unlocker.
- Debounces the five push-buttons and edge-detects them, then turns presses into a sequenced credential.
- Drives inputCount and the eight 4-bit digit registers: userNameInput0..3 first, then passwordInput0..3.
- Holds a full 8-digit entry until the unlocker pulses resetCount.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable cycles before a button level is accepted.
- ENTRY_TIMEOUT, 5000, idle cycles after which a partial entry (count 1..7) is discarded.

Ports:
- clk  in  1  system clock
- rst  in  1  reset. Asynchronous, active-high.
- btn1  in  1  raw button, digit value 0 (4 with switch1)
- btn2  in  1  raw button, digit value 1 (5 with switch1)
- btn3  in  1  raw button, digit value 2 (6 with switch1)
- btn4  in  1  raw button, digit value 3 (7 with switch1)
- btn5  in  1  raw button, backspace
- switch1  in  1  digit bank select; adds 4 to the digit value; sampled on the accepted press cycle
- locker  in  1  lockout active from the unlocker; while high, digit presses are ignored
- resetCount  in  1  1-cycle clear request from the unlocker
- inputCount  out  4  number of digits entered, 0..8
- userNameInput0..3  out  4 each  username digits 0..3
- passwordInput0..3  out  4 each  password digits 0..3

Behaviour:
- Reset (async, rst=1):
  - inputCount=0; all digit outputs=0.
  - Debounce counters and stable levels=0; timeout counter=0; state=EMPTY.
- Debounce, per button:
  - Synchronise through a 2-FF chain.
  - Accept a new level after DEBOUNCE_CYCLES consecutive equal samples.
  - A press = accepted 0->1 transition, a 1-cycle internal pulse.
  - Holding a button produces exactly one press.
- Digit write:
  - Digit value = {1'b0, switch1, idx[1:0]}, where idx = 0..3 for btn1..btn4.
  - Written to slot inputCount: slots 0..3 = userNameInput0..3, slots 4..7 = passwordInput0..3.
  - inputCount increments in the same cycle.
  - Outputs update on the clock edge after the press pulse: 1-cycle latency from pulse.
- States:
  - EMPTY (count 0):
    - digit press -> ENTRY.
    - backspace: no-op.
  - ENTRY (count 1..7):
    - digit press: write and increment; reaching 8 -> FULL.
    - backspace: decrement and zero the vacated slot; count reaching 0 -> EMPTY.
  - FULL (count 8):
    - all presses ignored; outputs held stable for the unlocker.
- Simultaneous events:
  - Two or more digit presses in one cycle: all ignored, count unchanged.
  - Digit press and backspace in one cycle: backspace wins, digit dropped.
  - resetCount has highest priority over any press that cycle.
- resetCount:
  - In any state: next edge gives inputCount=0, all digits=0, timeout cleared, state=EMPTY.
- locker=1:
  - Digit presses and backspace ignored.
  - resetCount still honoured.
  - Debouncers keep running, so no stale press fires when locker falls.
- Timeout:
  - In ENTRY, a counter increments each cycle with no accepted press.
  - Counter resets on any accepted press.
  - When it reaches ENTRY_TIMEOUT: clear all, as for resetCount, -> EMPTY.
  - Counter is inactive and zero in EMPTY and FULL.
- Width rules:
  - inputCount never exceeds 8 and never wraps below 0.
  - The timeout counter saturates; width = clog2(ENTRY_TIMEOUT+1).
- Reset mid-debounce or mid-entry: immediate async clear; no press pulse is emitted on release of rst.

Test Plan:
1. rst pulse mid-entry at count 3 -> all outputs 0 asynchronously, before the next clk edge.
2. Sequence btn1, btn1, btn2, btn2, btn2, btn1, btn2, btn2 with switch1=0; each button held 2*DEBOUNCE_CYCLES, then released for 2*DEBOUNCE_CYCLES:
   - Response: userNameInput0..3=0,0,1,1; passwordInput0..3=1,0,1,1; inputCount=8.
   - A 9th press leaves inputCount=8; a resetCount pulse then gives count 0 and all digits 0.
3. Bounce on btn3: toggling every 3 cycles for 40 cycles, then stable high with DEBOUNCE_CYCLES=16:
   - Exactly one press, inputCount 0->1, userNameInput0=2.
   - Repeat with switch1=1 -> next digit is 6.
4. Backspace and simultaneous presses:
   - Enter 3 digits, press btn5 twice -> inputCount=1, userNameInput1=userNameInput2=0.
   - btn5 at count 0 -> stays 0.
   - btn1+btn2 accepted in the same cycle -> count unchanged.
5. Lockout: locker=1, press btn1 four times -> inputCount stays 0. Drop locker, press btn4 -> inputCount=1, userNameInput0=3.
6. Timeout with ENTRY_TIMEOUT=100:
   - Enter 5 digits, idle 99 cycles -> count=5; cycle 100 -> count=0, all digits 0.
   - At count 8, idle 200 cycles -> count stays 8.

Source files
------------

// File: rtl/credential_entry_if.sv
// Credential entry bus: raw push-buttons, bank switch and unlocker controls
// going into the entry stage, plus the digit count and the eight digit
// registers coming out of it.
//   slave  : the entry stage (credential_entry)
//   master : the environment driving buttons and reading the credential
interface credential_entry_if;
  logic       btn1;
  logic       btn2;
  logic       btn3;
  logic       btn4;
  logic       btn5;
  logic       switch1;
  logic       locker;
  logic       resetCount;
  logic [3:0] inputCount;
  logic [3:0] userNameInput0;
  logic [3:0] userNameInput1;
  logic [3:0] userNameInput2;
  logic [3:0] userNameInput3;
  logic [3:0] passwordInput0;
  logic [3:0] passwordInput1;
  logic [3:0] passwordInput2;
  logic [3:0] passwordInput3;

  modport slave (
    input  btn1, btn2, btn3, btn4, btn5, switch1, locker, resetCount,
    output inputCount,
    output userNameInput0, userNameInput1, userNameInput2, userNameInput3,
    output passwordInput0, passwordInput1, passwordInput2, passwordInput3
  );

  modport master (
    output btn1, btn2, btn3, btn4, btn5, switch1, locker, resetCount,
    input  inputCount,
    input  userNameInput0, userNameInput1, userNameInput2, userNameInput3,
    input  passwordInput0, passwordInput1, passwordInput2, passwordInput3
  );
endinterface

// File: rtl/credential_entry.sv
// Credential entry stage, directly upstream of the unlocker.
// Debounces and edge-detects five push-buttons (btn1..btn4 digits,
// btn5 backspace) and assembles an 8-digit credential: four username
// digits followed by four password digits. A full entry is held until the
// unlocker pulses resetCount; a partial entry left idle for ENTRY_TIMEOUT
// cycles is discarded.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - credential_entry_if.slave (buttons, switch1, locker,
//          resetCount in; inputCount and digit registers out)
module credential_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned ENTRY_TIMEOUT   = 5000
) (
  input  logic               clk,
  input  logic               rst,
  credential_entry_if.slave  bus
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TO_W = $clog2(ENTRY_TIMEOUT + 1);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(ENTRY_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_SAT   = TO_W'(ENTRY_TIMEOUT);

  typedef enum logic [1:0] {
    EMPTY,
    ENTRY,
    FULL
  } state_e;

  // ---------------------------------------------------------------------
  // Button synchronisation and debouncing (bit 4 = backspace)
  // ---------------------------------------------------------------------
  logic [4:0]      raw;
  logic [4:0]      sync1_q, sync1_d;
  logic [4:0]      sync2_q, sync2_d;
  logic [4:0]      stable_q, stable_d;
  logic [4:0]      press_q, press_d;
  logic [DB_W-1:0] db_cnt_q [5];
  logic [DB_W-1:0] db_cnt_d [5];

  always_comb begin
    raw = {bus.btn5, bus.btn4, bus.btn3, bus.btn2, bus.btn1};
  end

  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    press_d  = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        // DEBOUNCE_CYCLES consecutive differing samples: accept the level;
        // only a rising acceptance is a press, so a held button fires once.
        stable_d[i] = sync2_q[i];
        press_d[i]  = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      press_q  <= '0;
      for (int unsigned i = 0; i < 5; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      for (int unsigned i = 0; i < 5; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      dig_q [8];
  logic [3:0]      dig_d [8];
  logic [TO_W-1:0] to_q, to_d;

  logic [3:0] digit_press;
  logic       single_digit;
  logic       any_press;
  logic [1:0] digit_idx;
  logic       bksp_ev;
  logic       digit_ev;
  logic       timeout_hit;
  logic       clear_ev;

  always_comb begin
    digit_press  = press_q[3:0];
    single_digit = (digit_press != 4'd0) &&
                   ((digit_press & (digit_press - 4'd1)) == 4'd0);
    any_press    = |press_q;

    case (digit_press)
      4'b0010: digit_idx = 2'd1;
      4'b0100: digit_idx = 2'd2;
      4'b1000: digit_idx = 2'd3;
      default: digit_idx = 2'd0;
    endcase

    // Backspace beats a same-cycle digit; locker masks both.
    bksp_ev  = !bus.locker && press_q[4] && (state_q == ENTRY);
    digit_ev = !bus.locker && !press_q[4] && single_digit &&
               (state_q != FULL);

    // Clears on the edge at which the idle count would reach ENTRY_TIMEOUT.
    timeout_hit = (state_q == ENTRY) && !any_press && (to_q == TO_LAST);
    clear_ev    = bus.resetCount || timeout_hit;
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (clear_ev) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (digit_ev) state_d = ENTRY;
        end
        ENTRY: begin
          if (bksp_ev && (cnt_q == 4'd1)) begin
            state_d = EMPTY;
          end else if (!bksp_ev && digit_ev && (cnt_q == 4'd7)) begin
            state_d = FULL;
          end
        end
        FULL:    state_d = FULL;
        default: state_d = EMPTY;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (count, digit registers, idle timer)
  // ---------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    to_d  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      dig_d[i] = dig_q[i];
    end

    if (clear_ev) begin
      cnt_d = '0;
      for (int unsigned i = 0; i < 8; i++) begin
        dig_d[i] = '0;
      end
    end else begin
      if (bksp_ev && (cnt_q != 4'd0)) begin
        cnt_d                 = cnt_q - 4'd1;
        dig_d[cnt_d[2:0]]     = '0;
      end else if (digit_ev && (cnt_q < 4'd8)) begin
        dig_d[cnt_q[2:0]]     = {1'b0, bus.switch1, digit_idx};
        cnt_d                 = cnt_q + 4'd1;
      end

      if ((state_q == ENTRY) && (state_d == ENTRY)) begin
        if (any_press) begin
          to_d = '0;
        end else if (to_q == TO_SAT) begin
          to_d = to_q;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      to_q  <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        dig_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
      for (int unsigned i = 0; i < 8; i++) begin
        dig_q[i] <= dig_d[i];
      end
    end
  end

  assign bus.inputCount     = cnt_q;
  assign bus.userNameInput0 = dig_q[0];
  assign bus.userNameInput1 = dig_q[1];
  assign bus.userNameInput2 = dig_q[2];
  assign bus.userNameInput3 = dig_q[3];
  assign bus.passwordInput0 = dig_q[4];
  assign bus.passwordInput1 = dig_q[5];
  assign bus.passwordInput2 = dig_q[6];
  assign bus.passwordInput3 = dig_q[7];

endmodule
